// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared types and constants for the divider arbiter slice.
//   div_state_t : arbiter FSM state encoding (IDLE, START, BUSY, RELEASE)
//   DIV_IN_W    : width of a mantissa fraction (hidden leading 1 implied)
//   DIV_Q_W     : width of the Q1.10 quotient returned by the divider
//   DIV_MAX_LAT : upper bound on grant-to-response latency, in cycles
// ---------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_IN_W    = 10;
    localparam int DIV_Q_W     = 11;
    localparam int DIV_MAX_LAT = 40;

    // Encodings are fixed so that legacy consumers comparing raw state bits
    // keep working.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        BUSY    = 2'd2,
        RELEASE = 2'd3
    } div_state_t;

endpackage : div_pkg

// File: rtl/div_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. The search for an eligible requester
// starts at ptr_i and wraps around modulo N; the first hit wins.
//   elig_i : eligible mask, one bit per requester
//   ptr_i  : index at which the search starts
//   gnt_o  : one-hot winner (all zero when nothing is eligible)
//   any_o  : high when at least one requester is eligible
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]                     elig_i,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr_i,
    output logic [N-1:0]                     gnt_o,
    output logic                             any_o
);

    localparam int PW  = (N > 1) ? $clog2(N) : 1;
    // One extra bit so ptr + offset cannot overflow before the wrap.
    localparam int PW1 = PW + 1;

    logic [N-1:0]   winner_s;
    logic           found_s;
    logic [PW1-1:0] sum_s;
    logic [PW-1:0]  idx_s;

    // Walk the requesters in rotated order starting at the pointer.
    always_comb begin
        winner_s = '0;
        found_s  = 1'b0;
        sum_s    = '0;
        idx_s    = '0;
        for (int k = 0; k < N; k++) begin
            sum_s = {1'b0, ptr_i} + PW1'(k);
            if (sum_s >= PW1'(N)) begin
                sum_s = sum_s - PW1'(N);
            end else begin
                sum_s = sum_s;
            end
            idx_s = sum_s[PW-1:0];
            if (!found_s && elig_i[idx_s]) begin
                winner_s[idx_s] = 1'b1;
                found_s         = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign gnt_o = winner_s;
    assign any_o = found_s;

endmodule : rr_pick

// File: rtl/div_arbiter.sv
// ---------------------------------------------------------------------------
// div_arbiter
// Round-robin scheduler sharing one external div11x11 restoring divider
// among N requesters. Each requester supplies two 10-bit mantissa fractions
// (hidden leading 1); the granted pair is latched onto the divider inputs,
// the st/done handshake is sequenced, and the Q1.10 quotient 1.a / 1.b is
// returned to the granted requester with a one-cycle valid pulse.
//
// Ports
//   clk, reset     : clock, synchronous active-high reset
//   req_i          : per-requester request level
//   a_i, b_i       : per-requester dividend / divisor fractions
//   gnt_o          : one-hot grant, high while that operation is in flight
//   rsp_valid_o    : one-hot, one-cycle response strobe
//   rsp_q_o        : quotient, holds its last value between responses
//   busy_o         : FSM not in IDLE
//   div_st_o       : divider start / release strobe
//   div_f1_o/f2_o  : divider operands, stable from grant until IDLE
//   div_done_i     : divider done
//   div_f_i        : divider quotient
// ---------------------------------------------------------------------------
module div_arbiter
    import div_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N-1:0]                 req_i,
    input  logic [N-1:0][DIV_IN_W-1:0]   a_i,
    input  logic [N-1:0][DIV_IN_W-1:0]   b_i,
    output logic [N-1:0]                 gnt_o,
    output logic [N-1:0]                 rsp_valid_o,
    output logic [DIV_Q_W-1:0]           rsp_q_o,
    output logic                         busy_o,
    output logic                         div_st_o,
    output logic [DIV_IN_W-1:0]          div_f1_o,
    output logic [DIV_IN_W-1:0]          div_f2_o,
    input  logic                         div_done_i,
    input  logic [DIV_Q_W-1:0]           div_f_i
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    div_state_t           state_q,     state_d;
    logic [N-1:0]         gnt_q,       gnt_d;
    logic [N-1:0]         rsp_valid_q, rsp_valid_d;
    logic [DIV_Q_W-1:0]   rsp_q_q,     rsp_q_d;
    logic                 busy_q,      busy_d;
    logic                 div_st_q,    div_st_d;
    logic [DIV_IN_W-1:0]  f1_q,        f1_d;
    logic [DIV_IN_W-1:0]  f2_q,        f2_d;
    logic [PW-1:0]        ptr_q,       ptr_d;

    logic [N-1:0]         elig_s;
    logic [N-1:0]         win_s;
    logic                 any_s;
    logic [DIV_IN_W-1:0]  a_sel_s;
    logic [DIV_IN_W-1:0]  b_sel_s;
    logic [PW-1:0]        win_idx_s;
    logic [PW-1:0]        ptr_nxt_s;

    // The requester whose response is landing this cycle still has its
    // (now stale) req high; mask it so it is not granted a second time.
    assign elig_s = req_i & ~rsp_valid_q;

    rr_pick #(
        .N (N)
    ) u_pick (
        .elig_i (elig_s),
        .ptr_i  (ptr_q),
        .gnt_o  (win_s),
        .any_o  (any_s)
    );

    // One-hot select of the winner's operands and its binary index.
    always_comb begin
        a_sel_s   = '0;
        b_sel_s   = '0;
        win_idx_s = '0;
        for (int i = 0; i < N; i++) begin
            a_sel_s   = a_sel_s   | (a_i[i] & {DIV_IN_W{win_s[i]}});
            b_sel_s   = b_sel_s   | (b_i[i] & {DIV_IN_W{win_s[i]}});
            win_idx_s = win_idx_s | (win_s[i] ? PW'(i) : PW'(0));
        end
    end

    // Pointer moves one past the winner, wrapping at N (N need not be 2^k).
    assign ptr_nxt_s = (win_idx_s == PW'(N - 1)) ? PW'(0) : (win_idx_s + PW'(1));

    // FSM next-state and output next-values.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rsp_valid_d = '0;
        rsp_q_d     = rsp_q_q;
        div_st_d    = 1'b0;
        f1_d        = f1_q;
        f2_d        = f2_q;
        ptr_d       = ptr_q;
        case (state_q)
            IDLE: begin
                if (any_s) begin
                    gnt_d    = win_s;
                    f1_d     = a_sel_s;
                    f2_d     = b_sel_s;
                    ptr_d    = ptr_nxt_s;
                    div_st_d = 1'b1;
                    state_d  = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                state_d = BUSY;
            end
            BUSY: begin
                if (div_done_i) begin
                    // Second st pulse returns the divider to its idle state.
                    div_st_d = 1'b1;
                    state_d  = RELEASE;
                end else begin
                    state_d = BUSY;
                end
            end
            RELEASE: begin
                rsp_q_d     = div_f_i;
                rsp_valid_d = gnt_q;
                gnt_d       = '0;
                state_d     = IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_q_q     <= '0;
            busy_q      <= 1'b0;
            div_st_q    <= 1'b0;
            f1_q        <= '0;
            f2_q        <= '0;
            ptr_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q_q     <= rsp_q_d;
            busy_q      <= busy_d;
            div_st_q    <= div_st_d;
            f1_q        <= f1_d;
            f2_q        <= f2_d;
            ptr_q       <= ptr_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_q_o     = rsp_q_q;
    assign busy_o      = busy_q;
    assign div_st_o    = div_st_q;
    assign div_f1_o    = f1_q;
    assign div_f2_o    = f2_q;

endmodule : div_arbiter

// File: tb/tb_div_arbiter.sv
// ---------------------------------------------------------------------------
// tb_div_arbiter
// Directed scoreboard bench for div_arbiter with a behavioural divider model
// standing in for div11x11 (st -> sample operands next cycle -> 22 + restore
// steps cycles -> done held until the next st).
// ---------------------------------------------------------------------------
module tb_div_arbiter;
    import div_pkg::*;

    localparam int N = 4;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [N-1:0]               req;
    logic [N-1:0][DIV_IN_W-1:0] a;
    logic [N-1:0][DIV_IN_W-1:0] b;
    logic [N-1:0]               gnt;
    logic [N-1:0]               rsp_valid;
    logic [DIV_Q_W-1:0]         rsp_q;
    logic                       busy;
    logic                       div_st;
    logic [DIV_IN_W-1:0]        div_f1;
    logic [DIV_IN_W-1:0]        div_f2;
    logic                       div_done;
    logic [DIV_Q_W-1:0]         div_f;

    always #5 clk = ~clk;

    div_arbiter #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req),
        .a_i         (a),
        .b_i         (b),
        .gnt_o       (gnt),
        .rsp_valid_o (rsp_valid),
        .rsp_q_o     (rsp_q),
        .busy_o      (busy),
        .div_st_o    (div_st),
        .div_f1_o    (div_f1),
        .div_f2_o    (div_f2),
        .div_done_i  (div_done),
        .div_f_i     (div_f)
    );

    // ---------------- divider model ----------------
    function automatic logic [10:0] ref_div(input logic [9:0] x, input logic [9:0] y);
        int unsigned n;
        int unsigned d;
        n = {11'd0, 1'b1, x, 10'd0};
        d = {21'd0, 1'b1, y};
        return 11'(n / d);
    endfunction

    int          dm_state = 0;
    int          dm_cnt   = 0;
    logic [10:0] dm_q     = 11'd0;

    always @(posedge clk) begin
        if (reset) begin
            dm_state <= 0;
            dm_cnt   <= 0;
            div_done <= 1'b0;
            div_f    <= 11'd0;
        end else begin
            case (dm_state)
                0: if (div_st) dm_state <= 1;
                1: begin
                    dm_q     <= ref_div(div_f1, div_f2);
                    dm_cnt   <= 32 - $countones(ref_div(div_f1, div_f2));
                    dm_state <= 2;
                end
                2: if (dm_cnt == 0) begin
                    div_done <= 1'b1;
                    div_f    <= dm_q;
                    dm_state <= 3;
                end else begin
                    dm_cnt <= dm_cnt - 1;
                end
                3: if (div_st) begin
                    div_done <= 1'b0;
                    dm_state <= 0;
                end
                default: dm_state <= 0;
            endcase
        end
    end

    // ---------------- checking infrastructure ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        int          idx;
        logic [10:0] q;
    } exp_t;

    exp_t sb[$];
    int   glog[$];
    int   cyc     = 0;
    int   st_cnt  = 0;
    int   rsp_cnt = 0;
    int   gnt_cyc [N];
    logic [N-1:0] gnt_prev = '0;

    always @(posedge clk) cyc++;

    // Monitor: log grants, pop the scoreboard on every response.
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                if (gnt[i] && !gnt_prev[i]) begin
                    gnt_cyc[i] = cyc;
                    glog.push_back(i);
                end
            end
            if (div_st) st_cnt++;
            if (rsp_valid != '0) begin
                rsp_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_valid_idx", 32'(rsp_valid), 32'(1 << e.idx));
                    check("rsp_q", 32'(rsp_q), 32'(e.q));
                    check("latency_max", 32'((cyc - gnt_cyc[e.idx]) <= DIV_MAX_LAT), 32'd1);
                    check("latency_min", 32'((cyc - gnt_cyc[e.idx]) >= 26), 32'd1);
                end
            end
        end
        gnt_prev = gnt;
    end

    // ---------------- requester model ----------------
    // Each requester holds req while it has outstanding issues and drops it
    // the edge after its response; reset abandons outstanding work.
    int issued [N];
    int served [N];

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (reset) served[i] = issued[i];
            else if (rsp_valid[i]) served[i] = served[i] + 1;
            req[i] = (issued[i] > served[i]);
        end
    end

    task automatic issue(input int idx, input logic [9:0] av, input logic [9:0] bv);
        a[idx] = av;
        b[idx] = bv;
        issued[idx] = issued[idx] + 1;
    endtask

    task automatic expect_rsp(input int idx, input logic [10:0] q);
        exp_t e;
        e.idx = idx;
        e.q   = q;
        sb.push_back(e);
    endtask

    task automatic drain(input string name, input int budget);
        int t;
        t = 0;
        @(negedge clk);
        while ((sb.size() != 0 || busy || req != '0) && t < budget) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(t < budget), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},       32'(gnt),       32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_q"},     32'(rsp_q),     32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_div_st"},    32'(div_st),    32'd0);
        check({tag, "_div_f1"},    32'(div_f1),    32'd0);
        check({tag, "_div_f2"},    32'(div_f2),    32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int fair_exp [5];
        int t;
        int rsp_before;
        fair_exp = '{0, 1, 2, 3, 0};
        reset = 1'b1;
        a     = '0;
        b     = '0;
        for (int i = 0; i < N; i++) begin
            issued[i] = 0;
            served[i] = 0;
        end
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        // Basic quotients.
        @(negedge clk); #1;
        expect_rsp(0, 11'h400); issue(0, 10'h000, 10'h000); drain("drain_t1", 200);
        #1; expect_rsp(2, 11'h600); issue(2, 10'h200, 10'h000); drain("drain_t2", 200);
        #1; expect_rsp(1, 11'h2AA); issue(1, 10'h000, 10'h200); drain("drain_t3", 200);

        // Operand extremes (last one on requester 3 leaves the pointer at 0).
        #1; expect_rsp(3, 11'h7FF); issue(3, 10'h3FF, 10'h000); drain("drain_max", 200);
        #1; expect_rsp(3, 11'h200); issue(3, 10'h000, 10'h3FF); drain("drain_min", 200);
        #1; expect_rsp(3, 11'h400); issue(3, 10'h3FF, 10'h3FF); drain("drain_eq", 200);

        // Fairness: all four at once, requester 0 wants two results.
        glog.delete();
        #1;
        expect_rsp(0, 11'h500);
        expect_rsp(1, 11'h480);
        expect_rsp(2, 11'h2AA);
        expect_rsp(3, 11'h400);
        expect_rsp(0, 11'h500);
        issue(0, 10'h100, 10'h000);
        issue(0, 10'h100, 10'h000);
        issue(1, 10'h080, 10'h000);
        issue(2, 10'h000, 10'h200);
        issue(3, 10'h200, 10'h200);
        drain("drain_fair", 600);
        check("fair_count", 32'(glog.size()), 32'd5);
        for (int i = 0; i < 5 && i < glog.size(); i++) begin
            check("fair_order", 32'(glog[i]), 32'(fair_exp[i]));
        end

        // Single requester, three back-to-back operations.
        glog.delete();
        st_cnt  = 0;
        rsp_cnt = 0;
        #1;
        expect_rsp(2, 11'h480);
        expect_rsp(2, 11'h480);
        expect_rsp(2, 11'h480);
        issue(2, 10'h080, 10'h000);
        issue(2, 10'h080, 10'h000);
        issue(2, 10'h080, 10'h000);
        drain("drain_b2b", 400);
        check("b2b_grants", 32'(glog.size()), 32'd3);
        check("b2b_rsp", 32'(rsp_cnt), 32'd3);
        check("b2b_div_st", 32'(st_cnt), 32'd6);

        // Operand change while BUSY is ignored.
        #1; expect_rsp(1, 11'h2AA); issue(1, 10'h000, 10'h200);
        repeat (12) @(negedge clk);
        #1; a[1] = 10'h3FF;
        drain("drain_opchg", 200);

        // Reset while BUSY aborts silently.
        #1; issue(0, 10'h100, 10'h000);
        t = 0;
        while (!busy && t < 20) begin @(negedge clk); t++; end
        repeat (10) @(negedge clk);
        check("abort_busy", 32'(busy), 32'd1);
        rsp_before = rsp_cnt;
        #1; reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("abort");
        @(negedge clk); #1;
        reset = 1'b0;
        repeat (50) @(negedge clk);
        check("abort_no_rsp", 32'(rsp_cnt), 32'(rsp_before));
        check("abort_idle", 32'(busy), 32'd0);
        #1; expect_rsp(0, 11'h7FF); issue(0, 10'h3FF, 10'h000); drain("drain_after_reset", 200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_div_arbiter
